// File: rtl/gray_conv_arbiter.sv
// Shared Gray-to-binary converter arbitrated among N_REQ requesters with a valid/ready result port.
// Define GRAY_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (0 highest) otherwise.
module gray_conv_arbiter #(
   parameter int unsigned N_REQ = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [4*N_REQ-1:0]   gray_in,
   input  logic                 out_ready,
   output logic [N_REQ-1:0]     grant,
   output logic [N_REQ-1:0]     ack,
   output logic                 bin_valid,
   output logic [3:0]           bin_out,
   output logic [1:0]           bin_id,
   output logic                 busy,
   output logic [7:0]           conv_count
);

   localparam int unsigned G_W  = 4;
   localparam int unsigned ID_W = 2;
   localparam int unsigned CNT_W = 8;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] CONV = 2'b01;
   localparam logic [1:0] HOLD = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [G_W-1:0]   operand_q, operand_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [N_REQ-1:0] grant_d, ack_d;
   logic             bin_valid_d, busy_d;
   logic [G_W-1:0]   bin_out_d;
   logic [ID_W-1:0]  bin_id_d;
   logic [CNT_W-1:0] conv_count_d;

   logic             win_found;
   logic [ID_W-1:0]  win_idx;

   function automatic logic [G_W-1:0] gray2bin(input logic [G_W-1:0] g);
      logic [G_W-1:0] b;
      b[G_W-1] = g[G_W-1];
      for (int i = int'(G_W) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

`ifdef GRAY_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0] last_q, last_d;
   logic [ID_W-1:0] cand;

   // Search starts one past the last-served requester and wraps.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= int'(N_REQ); k++) begin
         cand = last_q + ID_W'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end
`else
   // Lowest index wins.
   always_comb begin
      win_found = |req;
      win_idx   = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (req[i]) win_idx = ID_W'(i);
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         operand_q  <= '0;
         owner_q    <= '0;
         grant      <= '0;
         ack        <= '0;
         bin_valid  <= 1'b0;
         bin_out    <= '0;
         bin_id     <= '0;
         busy       <= 1'b0;
         conv_count <= '0;
`ifdef GRAY_ARB_ROUND_ROBIN_EN
         last_q     <= ID_W'(N_REQ - 1);
`endif
      end else begin
         state_q    <= state_d;
         operand_q  <= operand_d;
         owner_q    <= owner_d;
         grant      <= grant_d;
         ack        <= ack_d;
         bin_valid  <= bin_valid_d;
         bin_out    <= bin_out_d;
         bin_id     <= bin_id_d;
         busy       <= busy_d;
         conv_count <= conv_count_d;
`ifdef GRAY_ARB_ROUND_ROBIN_EN
         last_q     <= last_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      operand_d    = operand_q;
      owner_d      = owner_q;
      grant_d      = grant;
      ack_d        = '0;
      bin_valid_d  = bin_valid;
      bin_out_d    = bin_out;
      bin_id_d     = bin_id;
      conv_count_d = conv_count;
`ifdef GRAY_ARB_ROUND_ROBIN_EN
      last_d       = last_q;
`endif

      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d   = N_REQ'(1) << win_idx;
               operand_d = gray_in[G_W*win_idx +: G_W];
               owner_d   = win_idx;
`ifdef GRAY_ARB_ROUND_ROBIN_EN
               last_d    = win_idx;
`endif
               state_d   = CONV;
            end
         end
         CONV: begin
            bin_out_d   = gray2bin(operand_q);
            bin_id_d    = owner_q;
            bin_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (bin_valid && out_ready) begin
               bin_valid_d  = 1'b0;
               grant_d      = '0;
               ack_d        = N_REQ'(1) << bin_id;
               conv_count_d = conv_count + CNT_W'(1);
               state_d      = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            grant_d     = '0;
            bin_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter.
module tb_gray_conv_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] gray_in;
   logic        out_ready;
   logic [3:0]  grant;
   logic [3:0]  ack;
   logic        bin_valid;
   logic [3:0]  bin_out;
   logic [1:0]  bin_id;
   logic        busy;
   logic [7:0]  conv_count;

   int total = 0;
   int bad   = 0;

   logic [3:0] exp_bin_tab [4];

   gray_conv_arbiter #(.N_REQ(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gray_in(gray_in), .out_ready(out_ready),
      .grant(grant), .ack(ack), .bin_valid(bin_valid), .bin_out(bin_out),
      .bin_id(bin_id), .busy(busy), .conv_count(conv_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; req = '0; gray_in = '0; out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if ({grant, ack, bin_valid, bin_out, bin_id, busy, conv_count} !== 24'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0",
                  {grant, ack, bin_valid, bin_out, bin_id, busy, conv_count});
      end
   endtask

   task automatic test_basic();
      apply_reset();
      req = 4'b0001; gray_in = 16'h000D; out_ready = 1'b1;
      tick();
      total++;
      if (grant !== 4'b0001 || bin_valid !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL basic_grant grant=%b valid=%b busy=%b want 0001/0/1", grant, bin_valid, busy);
      end
      tick();
      total++;
      if (bin_valid !== 1'b1 || bin_out !== 4'b1001 || bin_id !== 2'd0) begin
         bad++; $display("FAIL basic_result valid=%b out=%b id=%0d want 1/1001/0", bin_valid, bin_out, bin_id);
      end
      tick();
      total++;
      if (ack !== 4'b0001 || grant !== 4'b0000 || bin_valid !== 1'b0 || conv_count !== 8'd1 || busy !== 1'b0) begin
         bad++; $display("FAIL basic_ack ack=%b grant=%b valid=%b cnt=%0d busy=%b want 0001/0000/0/1/0",
                         ack, grant, bin_valid, conv_count, busy);
      end
      req = 4'b0000;
      tick();
      total++;
      if (ack !== 4'b0000) begin
         bad++; $display("FAIL basic_ack_pulse ack=%b want=0000", ack);
      end
   endtask

   task automatic test_priority();
      logic [3:0] exp_grant;
      int         exp_idx;
      apply_reset();
      exp_bin_tab[0] = 4'b0000; exp_bin_tab[1] = 4'b0100;
      exp_bin_tab[2] = 4'b1111; exp_bin_tab[3] = 4'b1001;
      req = 4'b1111; gray_in = 16'b1101_1000_0110_0000; out_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
`ifdef GRAY_ARB_ROUND_ROBIN_EN
         exp_idx = n;
`else
         exp_idx = 0;
`endif
         exp_grant = 4'b0001 << exp_idx;
         tick();
         total++;
         if (grant !== exp_grant) begin
            bad++; $display("FAIL prio_grant[%0d] got=%b want=%b", n, grant, exp_grant);
         end
         tick();
         total++;
         if (bin_out !== exp_bin_tab[exp_idx] || bin_id !== 2'(exp_idx) || bin_valid !== 1'b1) begin
            bad++; $display("FAIL prio_result[%0d] out=%b id=%0d valid=%b want %b/%0d/1",
                            n, bin_out, bin_id, bin_valid, exp_bin_tab[exp_idx], exp_idx);
         end
         tick();
         total++;
         if (ack !== exp_grant || grant !== 4'b0000 || conv_count !== 8'(n + 1)) begin
            bad++; $display("FAIL prio_ack[%0d] ack=%b grant=%b cnt=%0d want %b/0000/%0d",
                            n, ack, grant, conv_count, exp_grant, n + 1);
         end
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_backpressure();
      apply_reset();
      req = 4'b0100; gray_in = 16'h0600; out_ready = 1'b0;
      tick();
      total++;
      if (grant !== 4'b0100) begin
         bad++; $display("FAIL bp_grant got=%b want=0100", grant);
      end
      tick();
      req = 4'b0000;
      for (int n = 0; n < 5; n++) begin
         total++;
         if (bin_valid !== 1'b1 || bin_out !== 4'b0100 || bin_id !== 2'd2 || ack !== 4'b0000 || grant !== 4'b0100) begin
            bad++; $display("FAIL bp_hold[%0d] valid=%b out=%b id=%0d ack=%b grant=%b want 1/0100/2/0000/0100",
                            n, bin_valid, bin_out, bin_id, ack, grant);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      total++;
      if (ack !== 4'b0100 || bin_valid !== 1'b0 || grant !== 4'b0000 || conv_count !== 8'd1) begin
         bad++; $display("FAIL bp_ack ack=%b valid=%b grant=%b cnt=%0d want 0100/0/0000/1",
                         ack, bin_valid, grant, conv_count);
      end
      tick();
      total++;
      if (busy !== 1'b0 || grant !== 4'b0000) begin
         bad++; $display("FAIL bp_idle busy=%b grant=%b want 0/0000", busy, grant);
      end
   endtask

   task automatic test_capture();
      apply_reset();
      req = 4'b0010; gray_in = 16'h0080; out_ready = 1'b1;
      tick();
      total++;
      if (grant !== 4'b0010) begin
         bad++; $display("FAIL cap_grant got=%b want=0010", grant);
      end
      gray_in = 16'h0000;
      tick();
      total++;
      if (bin_out !== 4'b1111 || bin_id !== 2'd1) begin
         bad++; $display("FAIL cap_result out=%b id=%0d want 1111/1", bin_out, bin_id);
      end
      tick();
      total++;
      if (ack !== 4'b0010 || (ack & grant) !== 4'b0000) begin
         bad++; $display("FAIL cap_ack ack=%b grant=%b want 0010/0000", ack, grant);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_mid_reset();
      apply_reset();
      req = 4'b0001; gray_in = 16'h0003; out_ready = 1'b0;
      tick();
      tick();
      total++;
      if (bin_valid !== 1'b1 || bin_out !== 4'b0010) begin
         bad++; $display("FAIL mr_hold valid=%b out=%b want 1/0010", bin_valid, bin_out);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({grant, ack, bin_valid, bin_out, bin_id, busy, conv_count} !== 24'h0) begin
         bad++; $display("FAIL mr_async got=%h want=0",
                         {grant, ack, bin_valid, bin_out, bin_id, busy, conv_count});
      end
      req = 4'b0000; out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         total++;
         if (ack !== 4'b0000 || bin_valid !== 1'b0 || conv_count !== 8'd0) begin
            bad++; $display("FAIL mr_no_ack[%0d] ack=%b valid=%b cnt=%0d want 0000/0/0", n, ack, bin_valid, conv_count);
         end
      end
   endtask

   task automatic test_wrap();
      int viol;
      apply_reset();
      viol = 0;
      req = 4'b1001; gray_in = 16'h5000; out_ready = 1'b1;
      for (int n = 1; n <= 256; n++) begin
         for (int c = 0; c < 3; c++) begin
            tick();
            if ($countones(grant) > 1 || (ack & grant) !== 4'b0000) viol++;
         end
         if (n == 255) begin
            total++;
            if (conv_count !== 8'd255) begin
               bad++; $display("FAIL wrap_255 got=%0d want=255", conv_count);
            end
         end
      end
      total++;
      if (conv_count !== 8'd0) begin
         bad++; $display("FAIL wrap_0 got=%0d want=0", conv_count);
      end
      total++;
      if (viol != 0) begin
         bad++; $display("FAIL wrap_onehot violations=%0d want=0", viol);
      end
      req = 4'b0000;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; req = '0; gray_in = '0; out_ready = 1'b0;
      test_reset();
      test_basic();
      test_priority();
      test_backpressure();
      test_capture();
      test_mid_reset();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
